// File: rtl/subleq_sequencer.sv
// SUBLEQ instruction sequencer: fetches A/B/C, reads both operands, writes mem[B]-mem[A]
// and branches to C when the widened result is <= 0. All C=all-ones branches halt.
module subleq_sequencer #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic [15:0]           instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_F_A = 3'd1, S_F_B = 3'd2, S_F_C = 3'd3,
    S_R_A  = 3'd4, S_R_B = 3'd5, S_WB  = 3'd6, S_HALT = 3'd7
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONES  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_THREE = ADDR_WIDTH'(3);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] pc_r, pc_s, a_r, a_s, b_r, b_s, c_r, c_s;
  logic [REG_WIDTH-1:0]  op_a_r, op_a_s;
  logic [15:0]           count_r, count_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
  logic                  mem_re_r, mem_re_s, mem_we_r, mem_we_s;
  logic                  busy_r, busy_s, halted_r, halted_s;
  logic [REG_WIDTH:0]    diff_s;
  logic                  take_s;

  // Widened signed subtraction so the branch test cannot overflow.
  always_comb begin
    diff_s = {mem_rdata[REG_WIDTH-1], mem_rdata} - {op_a_r[REG_WIDTH-1], op_a_r};
    take_s = diff_s[REG_WIDTH] | (diff_s == {(REG_WIDTH+1){1'b0}});
  end

  // Next state plus the bus/status values that go with that next state.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    a_s        = a_r;
    b_s        = b_r;
    c_s        = c_r;
    op_a_s     = op_a_r;
    count_s    = count_r;
    mem_re_s   = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = ADDR_ZERO;
    case (state_r)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_s       = start_addr;
          count_s    = 16'd0;
          state_s    = S_F_A;
          mem_re_s   = 1'b1;
          mem_addr_s = start_addr;
        end else begin
          state_s = state_r;
        end
      end
      S_F_A: begin
        state_s    = S_F_B;
        mem_re_s   = 1'b1;
        mem_addr_s = pc_r + ADDR_ONE;
      end
      S_F_B: begin
        a_s        = mem_rdata[ADDR_WIDTH-1:0];
        state_s    = S_F_C;
        mem_re_s   = 1'b1;
        mem_addr_s = pc_r + ADDR_TWO;
      end
      S_F_C: begin
        b_s        = mem_rdata[ADDR_WIDTH-1:0];
        state_s    = S_R_A;
        mem_re_s   = 1'b1;
        mem_addr_s = a_r;
      end
      S_R_A: begin
        c_s        = mem_rdata[ADDR_WIDTH-1:0];
        state_s    = S_R_B;
        mem_re_s   = 1'b1;
        mem_addr_s = b_r;
      end
      S_R_B: begin
        op_a_s     = mem_rdata;
        state_s    = S_WB;
        mem_we_s   = 1'b1;
        mem_addr_s = b_r;
      end
      S_WB: begin
        count_s = sat_inc(count_r);
        if (take_s) begin
          pc_s = c_r;
        end else begin
          pc_s = pc_r + ADDR_THREE;
        end
        if (take_s && (c_r == ADDR_ONES)) begin
          state_s = S_HALT;
        end else begin
          state_s    = S_F_A;
          mem_re_s   = 1'b1;
          mem_addr_s = pc_s;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s   = (state_s != S_IDLE) && (state_s != S_HALT);
    halted_s = (state_s == S_HALT);
  end

  // State, captured operands and registered bus/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      pc_r       <= ADDR_ZERO;
      a_r        <= ADDR_ZERO;
      b_r        <= ADDR_ZERO;
      c_r        <= ADDR_ZERO;
      op_a_r     <= {REG_WIDTH{1'b0}};
      count_r    <= 16'd0;
      mem_addr_r <= ADDR_ZERO;
      mem_re_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      a_r        <= a_s;
      b_r        <= b_s;
      c_r        <= c_s;
      op_a_r     <= op_a_s;
      count_r    <= count_s;
      mem_addr_r <= mem_addr_s;
      mem_re_r   <= mem_re_s;
      mem_we_r   <= mem_we_s;
      busy_r     <= busy_s;
      halted_r   <= halted_s;
    end
  end

  // Write data follows the B operand arriving during WB, so it cannot be registered.
  assign mem_wdata   = (state_r == S_WB) ? diff_s[REG_WIDTH-1:0] : {REG_WIDTH{1'b0}};
  assign mem_addr    = mem_addr_r;
  assign mem_re      = mem_re_r;
  assign mem_we      = mem_we_r;
  assign pc          = pc_r;
  assign busy        = busy_r;
  assign halted      = halted_r;
  assign instr_count = count_r;

endmodule
